// File: rtl/debug_loader_rx.sv
// Debug program loader: fills instruction memory over the debug write port,
// then releases the core and serves its instruction fetches from the same memory.
`timescale 1ns/1ps
module debug_loader_rx #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          DEBUG_SIG,
    input  logic [31:0]   DEBUG_addr,
    input  logic [31:0]   DEBUG_instr,
    input  logic          START,
    input  logic          fetch_en,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          fetch_valid,
    output logic          core_stall,
    output logic [AW:0]   load_count,
    output logic          load_err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    state_t       state;
    state_t       next_state;
    logic         wr_en;
    logic         mem_we;
    logic         addr_in_range;
    logic         fetch_oob;
    logic [AW-1:0] fetch_idx;
    logic         unused_fetch_lsbs;
    logic [31:0]  mem [DEPTH];

    // Handshake: DEBUG_SIG is a one-cycle write strobe with no back-pressure;
    // every high cycle in IDLE/LOAD is consumed at that edge, and it beats START.
    assign addr_in_range     = (DEBUG_addr[31:AW] == '0);
    assign fetch_oob         = (fetch_addr[31:AW+2] != '0);
    assign fetch_idx         = fetch_addr[AW+1:2];
    assign unused_fetch_lsbs = ^fetch_addr[1:0];
    assign dbg_state         = state;

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (DEBUG_SIG) begin
                    if (addr_in_range) begin
                        wr_en      = 1'b1;
                        next_state = LOAD;
                    end else begin
                        next_state = ERROR;
                    end
                end else if (START) begin
                    next_state = RUN;
                end
            end
            RUN, ERROR: next_state = state;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            core_stall <= 1'b1;
            load_err   <= 1'b0;
            load_count <= '0;
        end else begin
            state      <= next_state;
            core_stall <= (next_state != RUN);
            load_err   <= (next_state == ERROR);
            if (wr_en && (load_count != COUNT_MAX))
                load_count <= load_count + 1'b1;
        end
    end

    // Fetch port: only live in RUN, so it never overlaps a load write.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_valid <= 1'b0;
            fetch_instr <= NOP;
        end else if ((state == RUN) && fetch_en) begin
            fetch_valid <= 1'b1;
            fetch_instr <= fetch_oob ? NOP : mem[fetch_idx];
        end else begin
            fetch_valid <= 1'b0;
        end
    end

    // Memory contents deliberately survive reset.
    assign mem_we = wr_en & nrst;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[DEBUG_addr[AW-1:0]] <= DEBUG_instr;
    end

endmodule
